// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared RAM handshake and memory-controller types.
// Contents:
//   ramstate_t       - RAM port status reported back to the controller
//   memctl_state_t   - memory_control FSM states
//   BAD_WORD_DEFAULT - load value returned when a RAM access fails
package cpu_types_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DACC   = 2'd1,
        IACC   = 2'd2,
        HALTED = 2'd3
    } memctl_state_t;

    localparam logic [31:0] BAD_WORD_DEFAULT = 32'hBAD1BAD1;

endpackage

// File: rtl/memory_control_if.sv
// memory_control_if: CPU request/response and RAM port signals of memory_control.
// Modports:
//   slave  - memory_control: takes CPU requests and RAM status, drives waits, loads, RAM strobes
//   master - CPU datapath plus RAM: drives requests and RAM status, observes the rest
interface memory_control_if;
    import cpu_types_pkg::*;

    logic        halt;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    ramstate_t   ramstate;
    logic        mem_err;

    modport slave (
        input  halt, iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, mem_err
    );

    modport master (
        output halt, iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, mem_err
    );

endinterface

// File: rtl/memctl_timeout.sv
// memctl_timeout: per-transaction wait counter flagging when a RAM access has waited too long.
// Ports:
//   CLK, RST - clock, asynchronous active-high reset
//   clear    - hold the counter at zero (controller not in an access state)
//   enable   - count one waiting cycle
//   expired  - count has reached TIMEOUT; always low when TIMEOUT is 0
module memctl_timeout #(
    parameter int TIMEOUT = 255
) (
    input  logic CLK,
    input  logic RST,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT);

    logic [W-1:0] cnt;

    assign expired = (TIMEOUT != 0) && (cnt == LIMIT);

    // Reaching LIMIT ends the transaction, so holding at LIMIT is enough to avoid wrap.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (enable && !expired)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/memory_control.sv
// memory_control: serialises instruction fetches and data accesses onto one RAM port.
// Ports:
//   CLK, RST - clock, asynchronous active-high reset
//   bus      - memory_control_if.slave: CPU requests (halt, iREN/iaddr, dREN/dWEN/daddr/dstore),
//              handshakes (iwait/iload, dwait/dload), RAM port (ramREN/ramWEN/ramaddr/ramstore,
//              ramload/ramstate) and the sticky mem_err flag
// Data requests win over halt, halt wins over fetch; HALTED is left only through reset.
module memory_control
    import cpu_types_pkg::*;
#(
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] BAD_WORD = BAD_WORD_DEFAULT
) (
    input logic              CLK,
    input logic              RST,
    memory_control_if.slave  bus
);

    memctl_state_t state;
    logic          busy;
    logic          expired;
    logic          done;
    logic          fail;
    logic [31:0]   resp;

    assign busy = (state == DACC) || (state == IACC);
    assign done = busy && (bus.ramstate == ACCESS || bus.ramstate == ERROR || expired);
    assign fail = done && (bus.ramstate != ACCESS);
    // Writes return nothing on success; any failure returns the marker word.
    assign resp = fail ? BAD_WORD : (bus.ramWEN ? 32'h0 : bus.ramload);

    assign bus.dwait = !(state == DACC && done);
    assign bus.iwait = !(state == IACC && done);
    assign bus.dload = (state == DACC && done) ? resp : 32'h0;
    assign bus.iload = (state == IACC && done) ? resp : 32'h0;

    memctl_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .CLK     (CLK),
        .RST     (RST),
        .clear   (!busy),
        .enable  (busy),
        .expired (expired)
    );

    // The RAM strobe/address/data registers double as the latched request,
    // so a requester changing its inputs mid-transaction has no effect.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state        <= IDLE;
            bus.ramREN   <= 1'b0;
            bus.ramWEN   <= 1'b0;
            bus.ramaddr  <= 32'h0;
            bus.ramstore <= 32'h0;
            bus.mem_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.dREN || bus.dWEN) begin
                        state        <= DACC;
                        bus.ramREN   <= !bus.dWEN;
                        bus.ramWEN   <= bus.dWEN;
                        bus.ramaddr  <= bus.daddr;
                        bus.ramstore <= bus.dstore;
                    end else if (bus.halt) begin
                        state <= HALTED;
                    end else if (bus.iREN) begin
                        state        <= IACC;
                        bus.ramREN   <= 1'b1;
                        bus.ramWEN   <= 1'b0;
                        bus.ramaddr  <= bus.iaddr;
                        bus.ramstore <= 32'h0;
                    end
                end
                DACC, IACC: begin
                    if (done) begin
                        state        <= IDLE;
                        bus.ramREN   <= 1'b0;
                        bus.ramWEN   <= 1'b0;
                        bus.ramaddr  <= 32'h0;
                        bus.ramstore <= 32'h0;
                        if (fail)
                            bus.mem_err <= 1'b1;
                    end
                end
                default: state <= HALTED;
            endcase
        end
    end

endmodule
